gpu_span_walker: RTL and testbench

GPU_SPAN_WALKER -- requirements
Module: gpu_span_walker

---
 rtl/gpu_span_walker.sv | 107 ++++++++++
 tb/tb_gpu_span_walker.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_span_walker.sv
// Rectangle span walker: emits the 2-pixel pair columns of an inclusive rectangle, row by row,
// with per-pixel coverage masks, under a valid/ready handshake.
module gpu_span_walker (
  input  logic       clk,
  input  logic       nRst,
  input  logic       i_start,
  input  logic [9:0] i_x0,
  input  logic [9:0] i_x1,
  input  logic [8:0] i_y0,
  input  logic [8:0] i_y1,
  input  logic       i_abort,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_maskL,
  output logic       o_maskR,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t     state;
  logic [9:0] x0_q, x1_q;
  logic [8:0] y1_q;
  logic       xfer, row_end, last_pair;
  logic [9:0] nx, sx;
  logic [8:0] ny;

  // Pair stepping works on the pair index o_x[9:1] so x1=1023 ends at 1022 without wrapping.
  always_comb begin
    xfer      = o_valid & i_ready;
    row_end   = (o_x[9:1] == x1_q[9:1]);
    last_pair = row_end & (o_y == y1_q);
    nx        = row_end ? {x0_q[9:1], 1'b0} : {o_x[9:1] + 9'd1, 1'b0};
    ny        = row_end ? o_y + 9'd1 : o_y;
    sx        = {i_x0[9:1], 1'b0};
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state   <= IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      o_x     <= '0;
      o_y     <= '0;
      o_maskL <= 1'b0;
      o_maskR <= 1'b0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          x0_q   <= i_x0;
          x1_q   <= i_x1;
          y1_q   <= i_y1;
          o_busy <= 1'b1;
          if (i_x0 <= i_x1 && i_y0 <= i_y1) begin
            state   <= WALK;
            o_valid <= 1'b1;
            o_x     <= sx;
            o_y     <= i_y0;
            o_maskL <= (sx >= i_x0);
            o_maskR <= ({sx[9:1], 1'b1} <= i_x1);
          end else begin
            state  <= DONE;
            o_done <= 1'b1;
          end
        end
        WALK: begin
          if (i_abort) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
          end else if (xfer) begin
            if (last_pair) begin
              state   <= DONE;
              o_valid <= 1'b0;
              o_done  <= 1'b1;
            end else begin
              o_x     <= nx;
              o_y     <= ny;
              o_maskL <= (nx >= x0_q);
              o_maskR <= ({nx[9:1], 1'b1} <= x1_q);
            end
          end
        end
        DONE: begin
          // Abort here lands in IDLE too, so the same exit covers both cases.
          state  <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_span_walker.sv
// Self-checking bench for gpu_span_walker: queue-based reference of the pair stream,
// per-cycle output compare, literal checks on directed rectangles, random rectangles.
module tb_gpu_span_walker;

  logic       clk = 1'b0, nRst = 1'b0;
  logic       i_start = 1'b0, i_abort = 1'b0, i_ready = 1'b0;
  logic [9:0] i_x0 = '0, i_x1 = '0;
  logic [8:0] i_y0 = '0, i_y1 = '0;
  logic [9:0] o_x;
  logic [8:0] o_y;
  logic       o_maskL, o_maskR, o_valid, o_busy, o_done;

  gpu_span_walker dut (
    .clk(clk), .nRst(nRst), .i_start(i_start),
    .i_x0(i_x0), .i_x1(i_x1), .i_y0(i_y0), .i_y1(i_y1),
    .i_abort(i_abort), .o_x(o_x), .o_y(o_y),
    .o_maskL(o_maskL), .o_maskR(o_maskR), .o_valid(o_valid),
    .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       ml;
    logic       mr;
  } pair_t;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the remaining pairs of the walk as a queue, plus a phase (0 idle, 1 walk, 2 done).
  pair_t mq[$];
  int    mphase = 0;

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      mq.delete();
      mphase = 0;
    end else begin
      case (mphase)
        0: if (i_start) begin
          if (i_x0 <= i_x1 && i_y0 <= i_y1)
            for (int y = int'(i_y0); y <= int'(i_y1); y++)
              for (int p = int'(i_x0) / 2; p <= int'(i_x1) / 2; p++)
                mq.push_back('{x: 10'(2 * p), y: 9'(y),
                               ml: (2 * p >= int'(i_x0)), mr: (2 * p + 1 <= int'(i_x1))});
          mphase = (mq.size() > 0) ? 1 : 2;
        end
        1: if (i_abort) begin
          mq.delete();
          mphase = 0;
        end else if (i_ready) begin
          void'(mq.pop_front());
          if (mq.size() == 0) mphase = 2;
        end
        default: mphase = 0;
      endcase
    end
  end

  // Per-cycle compare plus a log of actual DUT transfers and done pulses.
  pair_t log_q[$];
  int    done_cnt = 0;
  logic  prev_valid = 1'b0;
  pair_t prev_pair;

  always @(negedge clk) begin
    if (!nRst) begin
      prev_valid = 1'b0;
    end else begin
      chk("valid", int'(o_valid), int'(mphase == 1));
      chk("busy", int'(o_busy), int'(mphase != 0));
      chk("done", int'(o_done), int'(mphase == 2));
      if (mphase == 1 && mq.size() > 0) begin
        chk("x", int'(o_x), int'(mq[0].x));
        chk("y", int'(o_y), int'(mq[0].y));
        chk("maskL", int'(o_maskL), int'(mq[0].ml));
        chk("maskR", int'(o_maskR), int'(mq[0].mr));
      end
      // i_ready/i_abort here are still the values seen at the edge that followed prev snapshot.
      if (prev_valid && i_ready && !i_abort) log_q.push_back(prev_pair);
      if (o_done) done_cnt++;
      prev_valid = o_valid;
      prev_pair  = '{x: o_x, y: o_y, ml: o_maskL, mr: o_maskR};
    end
  end

  int  rmode = 0;
  bit  noise = 1'b0;

  task automatic tick();
    @(negedge clk);
    #1;
    case (rmode)
      0: i_ready = 1'b1;
      1: i_ready = ~i_ready;
      default: i_ready = 1'($urandom_range(1));
    endcase
    if (noise) begin
      i_abort = ($urandom_range(49) == 0);
      i_start = ($urandom_range(9) == 0);
    end
  endtask

  task automatic start_rect(input int x0, input int x1, input int y0, input int y1);
    i_x0 = 10'(x0); i_x1 = 10'(x1); i_y0 = 9'(y0); i_y1 = 9'(y1);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int c = 0;
    while (mphase != 0 && c < maxc) begin
      tick();
      c++;
    end
    if (c >= maxc) chk("timeout", 1, 0);
    tick();
  endtask

  task automatic chk_log(input int i, input int x, input int y, input int ml, input int mr);
    if (i >= log_q.size()) begin
      chk("log_missing", i, log_q.size());
    end else begin
      chk("lit_x", int'(log_q[i].x), x);
      chk("lit_y", int'(log_q[i].y), y);
      chk("lit_maskL", int'(log_q[i].ml), ml);
      chk("lit_maskR", int'(log_q[i].mr), mr);
    end
  endtask

  task automatic chk_rect_3_6_10_11();
    chk("rect_pairs", log_q.size(), 6);
    for (int r = 0; r < 2; r++) begin
      chk_log(3 * r + 0, 2, 10 + r, 0, 1);
      chk_log(3 * r + 1, 4, 10 + r, 1, 1);
      chk_log(3 * r + 2, 6, 10 + r, 1, 0);
    end
    chk("rect_done", done_cnt, 1);
  endtask

  initial begin
    // Reset values while nRst is held low.
    #2;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_x", int'(o_x), 0);
    chk("rst_y", int'(o_y), 0);
    chk("rst_maskL", int'(o_maskL), 0);
    chk("rst_maskR", int'(o_maskR), 0);
    tick(); tick();
    nRst = 1'b1;
    tick();

    // Basic rectangle, always ready.
    rmode = 0; log_q.delete(); done_cnt = 0;
    start_rect(3, 6, 10, 11);
    wait_idle(50);
    chk_rect_3_6_10_11();

    // Same rectangle with ready toggling.
    rmode = 1; log_q.delete(); done_cnt = 0;
    start_rect(3, 6, 10, 11);
    wait_idle(50);
    chk_rect_3_6_10_11();

    // Right edge of the screen.
    rmode = 0; log_q.delete(); done_cnt = 0;
    start_rect(1020, 1023, 511, 511);
    wait_idle(50);
    chk("edge_pairs", log_q.size(), 2);
    chk_log(0, 1020, 511, 1, 1);
    chk_log(1, 1022, 511, 1, 1);
    chk("edge_done", done_cnt, 1);

    // Empty rectangle: straight to done.
    log_q.delete(); done_cnt = 0;
    start_rect(5, 4, 0, 0);
    chk("empty_busy", int'(o_busy), 1);
    chk("empty_done", int'(o_done), 1);
    wait_idle(10);
    chk("empty_pairs", log_q.size(), 0);
    chk("empty_done_cnt", done_cnt, 1);

    // Abort on the second pair together with ready, then a fresh start.
    log_q.delete(); done_cnt = 0;
    start_rect(0, 7, 0, 0);
    tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort_valid", int'(o_valid), 0);
    chk("abort_busy", int'(o_busy), 0);
    tick();
    chk("abort_pairs", log_q.size(), 1);
    chk("abort_no_done", done_cnt, 0);
    start_rect(2, 3, 5, 5);
    wait_idle(20);
    chk("restart_pairs", log_q.size(), 2);
    chk_log(1, 2, 5, 1, 1);
    chk("restart_done", done_cnt, 1);

    // Asynchronous reset in the middle of a walk.
    rmode = 2; log_q.delete(); done_cnt = 0;
    start_rect(0, 15, 0, 3);
    repeat (5) tick();
    #2;
    nRst = 1'b0;
    #1;
    chk("arst_valid", int'(o_valid), 0);
    chk("arst_busy", int'(o_busy), 0);
    chk("arst_x", int'(o_x), 0);
    chk("arst_y", int'(o_y), 0);
    chk("arst_maskL", int'(o_maskL), 0);
    chk("arst_maskR", int'(o_maskR), 0);
    tick(); tick();
    nRst = 1'b1;
    tick();

    // Start during a walk is ignored.
    log_q.delete(); done_cnt = 0;
    start_rect(0, 5, 0, 1);
    tick();
    start_rect(0, 1023, 0, 511);
    wait_idle(200);
    chk("ignore_start_pairs", log_q.size(), 6);
    chk("ignore_start_done", done_cnt, 1);

    // Random rectangles with random ready, aborts and stray starts.
    rmode = 2;
    for (int it = 0; it < 60; it++) begin
      int x0, x1, y0, y1;
      x0 = $urandom_range(1023);
      x1 = x0 + $urandom_range(11);
      if (x1 > 1023) x1 = 1023;
      y0 = $urandom_range(511);
      y1 = y0 + $urandom_range(3);
      if (y1 > 511) y1 = 511;
      if ($urandom_range(7) == 0) begin int t = x0; x0 = x1; x1 = t - 1; end
      start_rect(x0, x1, y0, y1);
      noise = 1'b1;
      wait_idle(400);
      noise = 1'b0;
      i_abort = 1'b0;
      i_start = 1'b0;
      wait_idle(400);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
